y86_fetch_prefetch: RTL and testbench

//  Parametrised Y86-64 fetch unit with a byte prefetch queue. Streams bytes from instruction memory
//  via valid/ready, decodes variable-length instructions (1/2/9/10 B) at queue head, presents them

---
 rtl/y86_fetch_prefetch.sv | 245 ++++++++++++++++++++++++
 tb/tb_y86_fetch_prefetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_prefetch.sv
// y86_fetch_prefetch: Y86-64 fetch unit with a byte prefetch queue.
// Memory beats are streamed into a circular byte queue. Variable-length
// instructions are decoded at the queue head and handed downstream over
// valid/ready. Later stages can redirect the PC.
// Optional feature macro: FETCH_STATS_EN adds the stall_cycles / insn_count ports.
module y86_fetch_prefetch #(
    parameter int unsigned       MEM_BYTES = 8,
    parameter int unsigned       DEPTH     = 32,
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_W-1:0]      imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [8*MEM_BYTES-1:0] imem_resp_data,
    input  logic                   imem_resp_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             icode,
    output logic [3:0]             ifun,
    output logic [3:0]             rA,
    output logic [3:0]             rB,
    output logic [63:0]            valC,
    output logic [ADDR_W-1:0]      valP,
    output logic [ADDR_W-1:0]      pc,
    output logic [2:0]             stat
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            insn_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PEEK  = 10;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } state_t;

    // Queue storage (no reset needed: occupancy is tracked by r_count)
    logic [7:0]        r_q_data [DEPTH];
    logic              r_q_err  [DEPTH];

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_addr;
    state_t            r_state;
    logic              r_outstanding;
    logic              r_drop;

    logic [7:0]        w_b [PEEK];
    logic              w_e [PEEK];
    logic [3:0]        w_len;
    logic              w_has_reg;
    logic [1:0]        w_valc_sel;
    logic [2:0]        w_stat_dec;
    logic              w_err_hit;
    logic              w_full;
    logic              w_valid;
    logic [63:0]       w_valc;
    logic [ADDR_W-1:0] w_valp;
    logic [2:0]        w_stat;
    logic [CNT_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_pop_n;
    logic              w_fire;
    logic              w_xfer;
    logic              w_push;

    // Peek the first PEEK bytes at the head; err flags only count for present bytes
    always_comb begin
        for (int k = 0; k < PEEK; k++) begin
            w_b[k] = r_q_data[r_rd_ptr + PTR_W'(k)];
            w_e[k] = r_q_err[r_rd_ptr + PTR_W'(k)] & (CNT_W'(k) < r_count);
        end
    end

    // Decode length, register byte, constant position and status from the head byte
    always_comb begin
        w_len      = 4'd1;
        w_has_reg  = 1'b0;
        w_valc_sel = 2'd0;
        w_stat_dec = STAT_AOK;
        w_err_hit  = 1'b0;
        w_valc     = '0;
        case (w_b[0][7:4])
            4'h0:                   w_stat_dec = STAT_HLT;
            4'h1, 4'h9:             w_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: begin
                w_len     = 4'd2;
                w_has_reg = 1'b1;
            end
            4'h7, 4'h8: begin
                w_len      = 4'd9;
                w_valc_sel = 2'd1;
            end
            4'h3, 4'h4, 4'h5: begin
                w_len      = 4'd10;
                w_has_reg  = 1'b1;
                w_valc_sel = 2'd2;
            end
            default:                w_stat_dec = STAT_INS;
        endcase
        // A faulty opcode byte carries no trustworthy length
        if (w_e[0]) begin
            w_len = 4'd1;
        end
        for (int k = 0; k < PEEK; k++) begin
            if (w_e[k] && (4'(k) < w_len)) begin
                w_err_hit = 1'b1;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (w_valc_sel == 2'd1) begin
                w_valc[8*k +: 8] = w_b[k+1];
            end else if (w_valc_sel == 2'd2) begin
                w_valc[8*k +: 8] = w_b[k+2];
            end
        end
    end

    // Handshake and queue bookkeeping terms
    always_comb begin
        w_full  = (r_count >= CNT_W'(w_len));
        w_valid = (r_state == S_RUN) && !redirect_valid && (w_full || w_err_hit);
        w_valp  = r_pc + ADDR_W'(w_len);
        w_stat  = w_err_hit ? STAT_ADR : w_stat_dec;
        w_free  = CNT_W'(DEPTH) - r_count;
        w_pop_n = w_full ? CNT_W'(w_len) : r_count;
        w_xfer  = w_valid && out_ready;
        w_push  = imem_resp_valid && r_outstanding && !r_drop && !redirect_valid;
    end

    // Memory request: one outstanding at most, only with room for a whole beat
    always_comb begin
        imem_req_valid = !rst && (r_state == S_RUN) && !r_outstanding && !redirect_valid
                         && (w_free >= CNT_W'(MEM_BYTES));
        imem_req_addr  = r_fetch_addr;
        w_fire         = imem_req_valid && imem_req_ready;
    end

    // Downstream outputs; idle values whenever nothing is presented
    always_comb begin
        out_valid = w_valid;
        icode     = w_valid ? w_b[0][7:4] : 4'h0;
        ifun      = w_valid ? w_b[0][3:0] : 4'h0;
        rA        = (w_valid && w_has_reg) ? w_b[1][7:4] : 4'hF;
        rB        = (w_valid && w_has_reg) ? w_b[1][3:0] : 4'hF;
        valC      = w_valid ? w_valc : 64'h0;
        valP      = w_valid ? w_valp : '0;
        pc        = r_pc;
        stat      = w_valid ? w_stat : 3'd0;
    end

    // Write an accepted response beat into the queue tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                r_q_data[r_wr_ptr + PTR_W'(i)] <= imem_resp_data[8*i +: 8];
                r_q_err[r_wr_ptr + PTR_W'(i)]  <= imem_resp_err;
            end
        end
    end

    // Control state: pointers, PCs, outstanding tracking and RUN/STOP state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_pc          <= RESET_PC;
            r_fetch_addr  <= RESET_PC;
            r_state       <= S_RUN;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else if (redirect_valid) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_pc          <= redirect_pc;
            r_fetch_addr  <= redirect_pc;
            r_state       <= S_RUN;
            // An in-flight beat still has to come back; remember to discard it
            r_outstanding <= r_outstanding && !imem_resp_valid;
            r_drop        <= r_outstanding && !imem_resp_valid;
        end else begin
            if (w_fire) begin
                r_fetch_addr  <= r_fetch_addr + ADDR_W'(MEM_BYTES);
                r_outstanding <= 1'b1;
            end else if (imem_resp_valid && r_outstanding) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(MEM_BYTES);
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
                r_pc     <= w_valp;
                if (w_stat != STAT_AOK) begin
                    r_state <= S_STOP;
                end
            end
            r_count <= r_count + (w_push ? CNT_W'(MEM_BYTES) : '0) - (w_xfer ? w_pop_n : '0);
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_insn_count;

    // Stall cycles saturate; transfer count wraps; redirect does not clear either
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_insn_count   <= '0;
        end else begin
            if ((r_state == S_RUN) && out_ready && !w_valid && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_xfer) begin
                r_insn_count <= r_insn_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign insn_count   = r_insn_count;
`endif

endmodule

// File: tb/tb_y86_fetch_prefetch.sv
// tb_y86_fetch_prefetch: directed checks of the Y86-64 prefetching fetch unit.
module tb_y86_fetch_prefetch;

    localparam int unsigned MEM_BYTES = 8;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned ADDR_W    = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   redirect_valid;
    logic [ADDR_W-1:0]      redirect_pc;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [ADDR_W-1:0]      imem_req_addr;
    logic                   imem_resp_valid;
    logic [8*MEM_BYTES-1:0] imem_resp_data;
    logic                   imem_resp_err;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             icode, ifun, rA, rB;
    logic [63:0]            valC;
    logic [ADDR_W-1:0]      valP, pc;
    logic [2:0]             stat;
`ifdef FETCH_STATS_EN
    logic [31:0]            stall_cycles, insn_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  mem [0:255];
    logic [63:0] err_lo, err_hi;
    int          mem_lat;
    logic [63:0] req_log[$];
    int          req_cyc[$];
    int          resp_cyc[$];

    y86_fetch_prefetch #(
        .MEM_BYTES(MEM_BYTES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(64'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .imem_resp_err(imem_resp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .pc(pc), .stat(stat)
`ifdef FETCH_STATS_EN
        , .stall_cycles(stall_cycles), .insn_count(insn_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: fixed latency, one beat per accepted request
    initial begin : mem_model
        int          cnt;
        logic [63:0] a;
        cnt = 0;
        a = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        for (int i = 0; i < MEM_BYTES; i++)
                            imem_resp_data[8*i +: 8] = mem[8'(a + 64'(i))];
                        imem_resp_err = (a >= err_lo) && (a < err_hi);
                        resp_cyc.push_back(cyc);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    a   = imem_req_addr;
                    cnt = mem_lat;
                    req_log.push_back(imem_req_addr);
                    req_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
        err_lo = 64'h0;
        err_hi = 64'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        req_log.delete();
        req_cyc.delete();
        resp_cyc.delete();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        fill_mem(8'h00);
        mem_lat = 1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if ({out_valid, imem_req_valid, icode, ifun, rA, rB, stat} !== {1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 3'd0}) begin
            errors++;
            $display("FAIL reset_ctl got %b%b %h %h %h %h %0d want 00 0 0 f f 0",
                     out_valid, imem_req_valid, icode, ifun, rA, rB, stat);
        end
        checks++;
        if ({valC, valP, pc, imem_req_addr} !== 256'h0) begin
            errors++;
            $display("FAIL reset_data valC %h valP %h pc %h addr %h want all 0", valC, valP, pc, imem_req_addr);
        end
    endtask

    task automatic test_irmovq();
        logic ok;
        fill_mem(8'h00);
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h23; mem[3] = 8'h01;
        mem_lat = 1;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL irmovq_timeout out_valid never 1"); end
        checks++;
        if (req_log.size() < 2 || req_log[0] !== 64'h0 || req_log[1] !== 64'h8) begin
            errors++;
            $display("FAIL irmovq_req_addr n=%0d first two want 0 8", req_log.size());
        end
        checks++;
        if ({icode, ifun, rA, rB, stat} !== {4'h3, 4'h0, 4'hF, 4'h3, 3'd1}) begin
            errors++;
            $display("FAIL irmovq_fields got %h %h %h %h %0d want 3 0 f 3 1", icode, ifun, rA, rB, stat);
        end
        checks++;
        if (valC !== 64'h123 || valP !== 64'd10 || pc !== 64'd0) begin
            errors++;
            $display("FAIL irmovq_vals valC %h valP %0d pc %0d want 123 10 0", valC, valP, pc);
        end
        checks++;
        if (resp_cyc.size() < 2 || cyc - resp_cyc[1] != 1) begin
            errors++;
            $display("FAIL irmovq_latency valid cyc %0d resp2 n=%0d want 1 cycle after", cyc, resp_cyc.size());
        end
    endtask

    task automatic test_stall_stream();
        logic ok;
        logic seen;
        fill_mem(8'h00);
        mem[0] = 8'h10; mem[1] = 8'h60; mem[2] = 8'h23; mem[3] = 8'h00;
        mem_lat = 1;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_timeout out_valid never 1"); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({out_valid, icode, ifun, rA, rB, valC, valP, pc, stat} !==
                {1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 64'd0, 3'd1}) begin
                errors++;
                $display("FAIL stream_frozen c%0d v%b i%h f%h %h %h valP %0d pc %0d st %0d want nop valP 1 pc 0",
                         c, out_valid, icode, ifun, rA, rB, valP, pc, stat);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, icode, valP} !== {1'b1, 4'h1, 64'd1}) begin
            errors++;
            $display("FAIL stream_nop v%b icode %h valP %0d want 1 1 1", out_valid, icode, valP);
        end
        tick();
        checks++;
        if ({out_valid, icode, ifun, rA, rB, valP, pc, stat} !== {1'b1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd3, 64'd1, 3'd1}) begin
            errors++;
            $display("FAIL stream_addq v%b %h %h %h %h valP %0d pc %0d st %0d want 1 6 0 2 3 3 1 1",
                     out_valid, icode, ifun, rA, rB, valP, pc, stat);
        end
        tick();
        checks++;
        if ({out_valid, icode, valP, pc, stat} !== {1'b1, 4'h0, 64'd4, 64'd3, 3'd2}) begin
            errors++;
            $display("FAIL stream_halt v%b icode %h valP %0d pc %0d st %0d want 1 0 4 3 2",
                     out_valid, icode, valP, pc, stat);
        end
        tick();
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (imem_req_valid || out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL stream_stop req/out valid seen 1 after halt want 0"); end
    endtask

    task automatic test_backpressure();
        logic ok;
        fill_mem(8'h10);
        mem_lat = 1;
        do_reset();
        repeat (20) tick();
        checks++;
        if (req_log.size() != 4 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_full reqs %0d req_valid %b want 4 0", req_log.size(), imem_req_valid);
        end
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_log.size() >= 5) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || req_log[4] !== 64'd32 || pc !== 64'd9) begin
            errors++;
            $display("FAIL bp_resume ok %b pc %0d want 5th req @32 when pc 9", ok, pc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        logic ok;
        fill_mem(8'h10);
        mem[8'h40] = 8'h60; mem[8'h41] = 8'h45;
        mem_lat = 4;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (req_log.size() >= 3) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || req_log[2] !== 64'h10) begin
            errors++;
            $display("FAIL redir_setup third req missing or not @10 ok %b", ok);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle out_valid %b req_valid %b want 0 0", out_valid, imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (pc !== 64'h40 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_after pc %h out_valid %b want 40 0", pc, out_valid);
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_log.size() >= 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || req_log[3] !== 64'h40 || resp_cyc.size() < 3 || req_cyc[3] != resp_cyc[2] + 1) begin
            errors++;
            $display("FAIL redir_newreq ok %b nresp %0d want req @40 one cycle after dropped beat", ok, resp_cyc.size());
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok || {pc, icode, rA, rB, valP} !== {64'h40, 4'h6, 4'h4, 4'h5, 64'h42}) begin
            errors++;
            $display("FAIL redir_first ok %b pc %h icode %h rA %h rB %h valP %h want 40 6 4 5 42",
                     ok, pc, icode, rA, rB, valP);
        end
    endtask

    task automatic test_addr_error();
        logic ok;
        logic seen;
        fill_mem(8'h10);
        mem[6] = 8'h70; mem[7] = 8'h00; mem[8'h30] = 8'hC0;
        err_lo = 64'h8;
        err_hi = 64'h20;
        mem_lat = 1;
        do_reset();
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid && pc === 64'd6) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok || {icode, stat, valP} !== {4'h7, 3'd3, 64'd15}) begin
            errors++;
            $display("FAIL adr_jxx ok %b icode %h stat %0d valP %0d want 7 3 15", ok, icode, stat, valP);
        end
        tick();
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (imem_req_valid || out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL adr_stop req/out valid seen 1 after ADR want 0"); end
        redirect_valid = 1'b1;
        redirect_pc = 64'h30;
        tick();
        redirect_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok || {icode, stat, pc, valP} !== {4'hC, 3'd4, 64'h30, 64'h31}) begin
            errors++;
            $display("FAIL ins_c0 ok %b icode %h stat %0d pc %h valP %h want c 4 30 31", ok, icode, stat, pc, valP);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ins_stop out_valid %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic ok;
        fill_mem(8'h10);
        mem_lat = 6;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_log.size() >= 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || req_log[1] !== 64'h8) begin errors++; $display("FAIL rstmid_setup second req missing ok %b", ok); end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, imem_req_valid, rA, rB, stat, pc, imem_req_addr, valP} !==
            {1'b0, 1'b0, 4'hF, 4'hF, 3'd0, 64'h0, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL rstmid_outputs v%b rq%b %h %h st %0d pc %h addr %h valP %h want 0 0 f f 0 0 0 0",
                     out_valid, imem_req_valid, rA, rB, stat, pc, imem_req_addr, valP);
        end
        tick();
        req_log.delete();
        req_cyc.delete();
        resp_cyc.delete();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_log.size() >= 1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || req_log[0] !== 64'h0) begin errors++; $display("FAIL rstmid_req first req after reset not @0 ok %b", ok); end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
        checks++;
        if (!ok || pc !== 64'h0 || icode !== 4'h1) begin
            errors++;
            $display("FAIL rstmid_first ok %b pc %h icode %h want 0 1", ok, pc, icode);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        err_lo = '0;
        err_hi = '0;
        mem_lat = 1;
        test_reset();
        test_irmovq();
        test_stall_stream();
        test_backpressure();
        test_redirect();
        test_addr_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
